// File: rtl/cpu_run_ctrl_if.sv
// Harness-side bundle for cpu_run_ctrl: launch/result handshake, CPU control and the
// debug byte port into D_MEM.
interface cpu_run_ctrl_if #(
   parameter int unsigned CW = 16
);
   logic          start;
   logic [15:0]   op0;
   logic [15:0]   op1;
   logic [15:0]   expected;
   logic          cpu_n_rst;
   logic          cpu_halt;
   logic          dmem_sel;
   logic          dmem_we;
   logic [7:0]    dmem_addr;
   logic [7:0]    dmem_wdata;
   logic [7:0]    dmem_rdata;
   logic          busy;
   logic          done;
   logic          pass;
   logic          timeout;
   logic [15:0]   result;
   logic [CW-1:0] run_cycles;

   modport master (
      output start, op0, op1, expected, cpu_halt, dmem_rdata,
      input  cpu_n_rst, dmem_sel, dmem_we, dmem_addr, dmem_wdata,
      input  busy, done, pass, timeout, result, run_cycles
   );

   modport slave (
      input  start, op0, op1, expected, cpu_halt, dmem_rdata,
      output cpu_n_rst, dmem_sel, dmem_we, dmem_addr, dmem_wdata,
      output busy, done, pass, timeout, result, run_cycles
   );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Runs one nand_cpu test: hold CPU in reset, load operands into D_MEM bytes 0-3,
// release the CPU, wait for halt or timeout, then read the result from bytes 4-5.
module cpu_run_ctrl #(
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 4096,
   parameter int unsigned CW         = 16
) (
   input logic           clk_i,
   input logic           n_rst_i,
   cpu_run_ctrl_if.slave ctrl_io
);
   // Phase counter shared by HOLD and LOAD; needs at least 2 bits for the LOAD index.
   localparam int unsigned PW = (RST_CYCLES > 4) ? $clog2(RST_CYCLES) : 2;
   localparam logic [PW-1:0] HoldLast = PW'(RST_CYCLES - 1);
   localparam logic [PW-1:0] LoadLast = PW'(3);
   localparam logic [CW-1:0] RunLast  = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle, StHold, StLoad, StRun, StRd0, StRd1, StRd2, StDone
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   cnt_q, cnt_d;
   logic [15:0]     op0_q, op0_d;
   logic [15:0]     op1_q, op1_d;
   logic [15:0]     exp_q, exp_d;
   logic [15:0]     result_q, result_d;
   logic            pass_q, pass_d;
   logic            timeout_q, timeout_d;
   logic [CW-1:0]   run_cycles_q, run_cycles_d;

   logic            accept;
   logic            run_o, load_o;
   logic [7:0]      addr_o, wdata_o;

   assign accept = ((state_q == StIdle) || (state_q == StDone)) && ctrl_io.start;

   always_ff @(posedge clk_i) begin
      if (!n_rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: if (ctrl_io.start) state_d = StHold;
         StHold:         if (cnt_q == HoldLast) state_d = StLoad;
         StLoad:         if (cnt_q == LoadLast) state_d = StRun;
         StRun: begin
            if (ctrl_io.cpu_halt)          state_d = StRd0;
            else if (run_cycles_q == RunLast) state_d = StDone;
         end
         StRd0:          state_d = StRd1;
         StRd1:          state_d = StRd2;
         StRd2:          state_d = StDone;
         default:        state_d = StIdle;
      endcase
   end

   always_comb begin
      run_o   = (state_q == StRun);
      load_o  = (state_q == StLoad);
      addr_o  = 8'd0;
      wdata_o = 8'd0;
      unique case (state_q)
         StLoad: begin
            addr_o = {6'd0, cnt_q[1:0]};
            unique case (cnt_q[1:0])
               2'd0:    wdata_o = op0_q[7:0];
               2'd1:    wdata_o = op0_q[15:8];
               2'd2:    wdata_o = op1_q[7:0];
               default: wdata_o = op1_q[15:8];
            endcase
         end
         StRd0:   addr_o = 8'd4;
         StRd1:   addr_o = 8'd5;
         default: addr_o = 8'd0;
      endcase
   end

   assign ctrl_io.cpu_n_rst  = run_o;
   assign ctrl_io.dmem_sel   = ~run_o;
   assign ctrl_io.dmem_we    = load_o;
   assign ctrl_io.dmem_addr  = addr_o;
   assign ctrl_io.dmem_wdata = wdata_o;
   assign ctrl_io.busy       = (state_q != StIdle) && (state_q != StDone);
   assign ctrl_io.done       = (state_q == StDone);
   assign ctrl_io.pass       = pass_q;
   assign ctrl_io.timeout    = timeout_q;
   assign ctrl_io.result     = result_q;
   assign ctrl_io.run_cycles = run_cycles_q;

   always_comb begin
      cnt_d        = '0;
      op0_d        = op0_q;
      op1_d        = op1_q;
      exp_d        = exp_q;
      result_d     = result_q;
      pass_d       = pass_q;
      timeout_d    = timeout_q;
      run_cycles_d = run_cycles_q;

      if (((state_q == StHold) || (state_q == StLoad)) && (state_d == state_q)) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (accept) begin
         op0_d     = ctrl_io.op0;
         op1_d     = ctrl_io.op1;
         exp_d     = ctrl_io.expected;
         result_d  = '0;
         pass_d    = 1'b0;
         timeout_d = 1'b0;
      end

      if (state_q == StLoad && state_d == StRun) begin
         run_cycles_d = '0;
      end else if (state_q == StRun) begin
         run_cycles_d = run_cycles_q + 1'b1;
         if (state_d == StDone) begin
            timeout_d = 1'b1;
            pass_d    = 1'b0;
         end
      end

      if (state_q == StRd1) result_d[7:0] = ctrl_io.dmem_rdata;
      // timeout_q is always clear on this path, so only the compare decides pass.
      if (state_q == StRd2) begin
         result_d[15:8] = ctrl_io.dmem_rdata;
         pass_d         = ({ctrl_io.dmem_rdata, result_q[7:0]} == exp_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!n_rst_i) begin
         cnt_q        <= '0;
         op0_q        <= '0;
         op1_q        <= '0;
         exp_q        <= '0;
         result_q     <= '0;
         pass_q       <= 1'b0;
         timeout_q    <= 1'b0;
         run_cycles_q <= '0;
      end else begin
         cnt_q        <= cnt_d;
         op0_q        <= op0_d;
         op1_q        <= op1_d;
         exp_q        <= exp_d;
         result_q     <= result_d;
         pass_q       <= pass_d;
         timeout_q    <= timeout_d;
         run_cycles_q <= run_cycles_d;
      end
   end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a byte-wide D_MEM and a scripted CPU stand-in.
module tb_cpu_run_ctrl;
   localparam int unsigned CW = 16;

   logic clk;
   logic n_rst;

   cpu_run_ctrl_if #(.CW(CW)) bus ();

   cpu_run_ctrl #(
      .RST_CYCLES(2),
      .TIMEOUT   (64),
      .CW        (CW)
   ) dut (
      .clk_i  (clk),
      .n_rst_i(n_rst),
      .ctrl_io(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // D_MEM plus a CPU stand-in: stores cpu_res into bytes 4/5, halts after 20 run cycles.
   logic [7:0]  mem [256];
   logic [7:0]  cpu_cnt;
   logic [15:0] cpu_res;
   logic        halt_en;

   always @(posedge clk) begin
      if (!bus.cpu_n_rst) cpu_cnt <= 8'd0;
      else                cpu_cnt <= cpu_cnt + 8'd1;
      if (bus.dmem_sel && bus.dmem_we) mem[bus.dmem_addr] <= bus.dmem_wdata;
      else if (!bus.dmem_sel && cpu_cnt == 8'd2) mem[4] <= cpu_res[7:0];
      else if (!bus.dmem_sel && cpu_cnt == 8'd3) mem[5] <= cpu_res[15:8];
      bus.dmem_rdata <= mem[bus.dmem_addr];
   end

   assign bus.cpu_halt = halt_en && bus.cpu_n_rst && (cpu_cnt >= 8'd19);

   int n_checks = 0;
   int n_errors = 0;
   int cyc;
   int done_cyc;
   int last_run;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Leaves the bench in cycle 1 (first HOLD cycle) with start low again.
   task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
      bus.start    = 1'b1;
      bus.op0      = a;
      bus.op1      = b;
      bus.expected = e;
      cyc = 0;
      step();
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      last_run = -1;
      while (!bus.done && cyc < 400) begin
         if (bus.cpu_n_rst) last_run = cyc;
         step();
      end
      done_cyc = cyc;
      check("done_seen", {31'd0, bus.done}, 32'd1);
   endtask

   initial begin
      n_rst        = 1'b0;
      bus.start    = 1'b0;
      bus.op0      = 16'h0;
      bus.op1      = 16'h0;
      bus.expected = 16'h0;
      cpu_res      = 16'h2143;
      halt_en      = 1'b1;
      cyc          = 0;
      step();
      step();
      check("rst_cpu_n_rst", {31'd0, bus.cpu_n_rst}, 32'd0);
      check("rst_dmem_sel", {31'd0, bus.dmem_sel}, 32'd1);
      check("rst_outs", {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, bus.busy, bus.done,
                         bus.pass, bus.timeout}, 32'd0);
      check("rst_result", {16'd0, bus.result}, 32'd0);
      check("rst_run_cycles", {16'd0, bus.run_cycles}, 32'd0);
      n_rst = 1'b1;
      step();

      // Matching result, 20 RUN cycles.
      launch(16'h1234, 16'h0F0F, 16'h2143);
      check("hold_busy_rst", {30'd0, bus.busy, bus.cpu_n_rst}, 32'd2);
      check("hold_no_we", {31'd0, bus.dmem_we}, 32'd0);
      step();
      step();
      check("load0", {15'd0, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, 32'h10034);
      step();
      check("load1", {15'd0, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, 32'h10112);
      step();
      step();
      check("load3", {15'd0, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, 32'h1030F);
      step();
      check("run_owner", {30'd0, bus.cpu_n_rst, bus.dmem_sel}, 32'd2);
      wait_done();
      check("t1_latency", done_cyc, 32'd30);
      check("t1_bytes", {mem[3], mem[2], mem[1], mem[0]}, 32'h0F0F1234);
      check("t1_pass", {30'd0, bus.pass, bus.timeout}, 32'd2);
      check("t1_result", {16'd0, bus.result}, 32'h2143);
      check("t1_run_cycles", {16'd0, bus.run_cycles}, 32'd20);
      check("t1_cpu_held", {30'd0, bus.cpu_n_rst, bus.busy}, 32'd0);

      // Back-to-back relaunch from DONE with a wrong expectation.
      launch(16'h1234, 16'h0F0F, 16'h2144);
      check("t2_cleared", {15'd0, bus.pass, bus.result}, 32'd0);
      wait_done();
      check("t2_pass", {30'd0, bus.pass, bus.timeout}, 32'd0);
      check("t2_result", {16'd0, bus.result}, 32'h2143);

      // CPU never halts.
      halt_en = 1'b0;
      launch(16'hBEEF, 16'hCAFE, 16'h2143);
      wait_done();
      halt_en = 1'b1;
      check("t3_last_run", last_run, 32'd70);
      check("t3_latency", done_cyc, 32'd71);
      check("t3_flags", {30'd0, bus.pass, bus.timeout}, 32'd1);
      check("t3_run_cycles", {16'd0, bus.run_cycles}, 32'd64);
      check("t3_result", {16'd0, bus.result}, 32'd0);

      // start during LOAD is ignored.
      cpu_res = 16'h0F0F;
      launch(16'hA55A, 16'h3CC3, 16'h0F0F);
      step();
      step();
      bus.start    = 1'b1;
      bus.op0      = 16'h1111;
      bus.op1      = 16'h2222;
      bus.expected = 16'h3333;
      step();
      bus.start = 1'b0;
      wait_done();
      check("t4_latency", done_cyc, 32'd30);
      check("t4_bytes", {mem[3], mem[2], mem[1], mem[0]}, 32'h3CC3A55A);
      check("t4_pass", {30'd0, bus.pass, bus.timeout}, 32'd2);

      // Reset in the middle of RUN.
      launch(16'h0101, 16'h0202, 16'h0F0F);
      while (cyc < 12) step();
      check("t5_running", {31'd0, bus.cpu_n_rst}, 32'd1);
      n_rst = 1'b0;
      step();
      check("t5_cpu_held", {30'd0, bus.cpu_n_rst, bus.dmem_sel}, 32'd1);
      check("t5_flags", {28'd0, bus.busy, bus.done, bus.pass, bus.timeout}, 32'd0);
      check("t5_data", {bus.result, bus.run_cycles}, 32'd0);
      n_rst = 1'b1;
      step();

      // add_short-style run: 0xFFFF + 0x0001 = 0x0000, twice back to back.
      cpu_res = 16'h0000;
      launch(16'hFFFF, 16'h0001, 16'h0000);
      wait_done();
      check("t6_pass", {30'd0, bus.pass, bus.timeout}, 32'd2);
      check("t6_result", {16'd0, bus.result}, 32'd0);
      check("t6_bytes", {mem[3], mem[2], mem[1], mem[0]}, 32'h0001FFFF);
      launch(16'hFFFF, 16'h0001, 16'h0000);
      check("t7_cleared", {30'd0, bus.pass, bus.busy}, 32'd1);
      wait_done();
      check("t7_pass", {30'd0, bus.pass, bus.timeout}, 32'd2);
      check("t7_latency", done_cyc, 32'd30);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Sequencer that runs one complete nand_cpu test without a bench poking memory hierarchically. It holds the CPU in reset, writes two 16-bit operands into data memory bytes 0-3, and releases the CPU. It then waits for halt or a timeout, reads the 16-bit result from bytes 4-5, and reports pass/fail against an expected value. It sits between the top-level harness and the CPU's n_rst pin and owns a debug port muxed into D_MEM.

Parameters:
RST_CYCLES, 2, cycles cpu_n_rst is held low before loading (must be >= 1)
TIMEOUT, 4096, maximum RUN cycles before abort (must be >= 2)
CW, 16, width of the run-cycle counter (must satisfy 2^CW > TIMEOUT)

Ports:
clk  in  1  system clock; all logic on the rising edge
n_rst  in  1  synchronous active-low reset
start  in  1  one-cycle request; accepted only in IDLE or DONE
op0  in  16  first operand; sampled on the accepting cycle
op1  in  16  second operand; sampled on the accepting cycle
expected  in  16  expected result; sampled on the accepting cycle
cpu_n_rst  out  1  drives CPU n_rst (active-low)
cpu_halt  in  1  CPU halt output
dmem_sel  out  1  1 selects the debug port onto D_MEM; 0 gives the CPU ownership
dmem_we  out  1  debug byte-write enable
dmem_addr  out  8  debug byte address
dmem_wdata  out  8  debug write byte
dmem_rdata  in  8  D_MEM read byte; synchronous read, valid one cycle after dmem_addr
busy  out  1  high in every state except IDLE and DONE
done  out  1  high while in DONE
pass  out  1  valid when done=1; 1 = result matches expected and no timeout
timeout  out  1  valid when done=1; 1 = RUN aborted without halt
result  out  16  result read from {byte5, byte4}; valid when done=1
run_cycles  out  CW  cycles spent in RUN; valid when done=1

Behaviour:
- Reset (n_rst=0 at a clock edge):
  - State goes to IDLE.
  - cpu_n_rst=0, dmem_sel=1, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - busy=0, done=0, pass=0, timeout=0, result=0, run_cycles=0.
  - Reset mid-run aborts immediately; the CPU is held in reset from that edge.
- Outside RUN: cpu_n_rst=0 and dmem_sel=1 in every state, so the CPU never runs while the debug port owns memory.
- IDLE: wait for start. On start, latch op0/op1/expected, clear the result flags, and go to HOLD.
- HOLD: RST_CYCLES cycles, cpu_n_rst=0, no writes. Then go to LOAD.
- LOAD: 4 consecutive cycles, dmem_we=1, writing:
  - addr 0 = op0[7:0]
  - addr 1 = op0[15:8]
  - addr 2 = op1[7:0]
  - addr 3 = op1[15:8]
  Then go to RUN. dmem_we=0 in all other states.
- RUN: cpu_n_rst=1, dmem_sel=0.
  - run_cycles clears on entry and increments every RUN cycle.
  - If cpu_halt=1 is sampled, go to RD0.
  - Else if run_cycles reaches TIMEOUT-1, set timeout=1 and go to DONE with pass=0; result keeps its cleared value.
  - Halt and timeout on the same cycle: halt wins.
- RD0: dmem_addr=4.
- RD1: dmem_addr=5; capture dmem_rdata into result[7:0].
- RD2: capture dmem_rdata into result[15:8]; go to DONE.
- DONE: done=1.
  - pass = (result == expected) and not timeout; registered on entry and stable until the next start.
  - start in DONE behaves as in IDLE (re-launch, flags cleared on acceptance).
- start while busy=1: ignored, with no effect on latched operands.
- Latency, start accepted at cycle 0:
  - HOLD = cycles 1..RST_CYCLES, LOAD = next 4 cycles.
  - For halt seen at RUN cycle k (run_cycles=k): DONE is 3 cycles after RUN exit.
  - done asserts at cycle RST_CYCLES+4+(k+1)+3+1.
- Operands are raw 16-bit values; no arithmetic inside the block beyond the equality compare and the counter.

Test Plan:
- op0=0x1234, op1=0x0F0F, expected=0x2143, CPU model writes 0x43/0x21 to bytes 4/5 then halts after 20 cycles -> LOAD writes 34,12,0F,0F to addrs 0-3; done=1, pass=1, result=0x2143, run_cycles=20.
- Same run with expected=0x2144 -> done=1, pass=0, timeout=0, result=0x2143.
- CPU never halts, TIMEOUT=64 -> exactly 64 RUN cycles; timeout=1, pass=0, cpu_n_rst returns to 0 on the cycle after the last RUN cycle.
- start pulsed during LOAD with different operands -> ignored; original bytes written, no restart.
- n_rst=0 during RUN -> next edge: cpu_n_rst=0, busy=0, done=0, all flags 0; then start runs normally.
- op0=0xFFFF, op1=0x0001, expected=0x0000, real nand_cpu running add_short.bin -> done=1, pass=1, result=0x0000; back-to-back second start from DONE clears flags and passes again.
